// File: rtl/arith_share_ctrl.sv
// arith_share_ctrl: shares one combinational arithmetic unit between two
// requesters. A round-robin winner's operands are latched onto the unit
// inputs, held for SETTLE cycles, then the result is captured and returned
// with a one-cycle done pulse to the granted requester.
//
// Handshake: a requester raises req[i] with stable operands and holds it
// until it sees done[i]; it drops req[i] before the controller is back in
// IDLE. A req still high in IDLE is taken as a new request.
module arith_share_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [3:0] x0,
    input  logic [3:0] y0,
    input  logic [1:0] op0,
    input  logic [3:0] x1,
    input  logic [3:0] y1,
    input  logic [1:0] op1,
    output logic [3:0] alu_x,
    output logic [3:0] alu_y,
    output logic [1:0] alu_s,
    input  logic [8:0] alu_out,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [8:0] result,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q, done_d;
    logic [8:0] result_q, result_d;
    logic [3:0] alu_x_q, alu_x_d;
    logic [3:0] alu_y_q, alu_y_d;
    logic [1:0] alu_s_q, alu_s_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // index of the most recently granted requester
    logic       win;              // index of the requester that wins this cycle
    logic [8:0] masked;

    // Round-robin pick: a lone request wins; on a tie the one not served last wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ~last_q;
        end else if (req[1]) begin
            win = 1'b1;
        end
    end

    // Add/sub leave bits [7:4] of the unit output undriven, so they are forced to zero.
    always_comb begin
        masked = alu_out;
        if (!alu_s_q[1]) begin
            masked = {alu_out[8], 4'b0000, alu_out[3:0]};
        end
    end

    // Next-state and datapath update for the IDLE -> EXEC -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = 2'b00;
        result_d = result_q;
        alu_x_d  = alu_x_q;
        alu_y_d  = alu_y_q;
        alu_s_d  = alu_s_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    alu_x_d = win ? x1 : x0;
                    alu_y_d = win ? y1 : y0;
                    alu_s_d = win ? op1 : op0;
                    cnt_d   = SETTLE_M1;
                    last_d  = win;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = masked;
                    done_d   = grant_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            result_q <= 9'd0;
            alu_x_q  <= 4'd0;
            alu_y_q  <= 4'd0;
            alu_s_q  <= 2'd0;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            alu_x_q  <= alu_x_d;
            alu_y_q  <= alu_y_d;
            alu_s_q  <= alu_s_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_s     = alu_s_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_arith_share_ctrl.sv
// Bench for arith_share_ctrl: a SETTLE=1 instance checked through a
// scoreboard/monitor pair, and a SETTLE=3 instance used for the
// mid-transaction reset scenario.
module tb_arith_share_ctrl;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst3_n;

    // ---------------- instance A (SETTLE=1) ----------------
    logic [1:0] req;
    logic [3:0] x0, y0, x1, y1;
    logic [1:0] op0, op1;
    logic [3:0] alu_x, alu_y;
    logic [1:0] alu_s;
    logic [8:0] alu_out;
    logic [1:0] grant, done, dbg_state;
    logic [8:0] result;
    logic       busy;

    // ---------------- instance B (SETTLE=3) ----------------
    logic [1:0] req3;
    logic [3:0] x03, y03, x13, y13;
    logic [1:0] op03, op13;
    logic [3:0] alu_x3, alu_y3;
    logic [1:0] alu_s3;
    logic [8:0] alu_out3;
    logic [1:0] grant3, done3, dbg_state3;
    logic [8:0] result3;
    logic       busy3;

    // Stand-in arithmetic unit. Bits [7:4] carry junk for add/sub so the
    // controller's masking is exercised.
    function automatic logic [8:0] alu_model(input logic [3:0] x, input logic [3:0] y,
                                             input logic [1:0] s);
        logic [4:0] t;
        logic [8:0] p;
        p = {5'b0, x} * {5'b0, y};
        case (s)
            2'd0: begin t = {1'b0, x} + {1'b0, y}; return {t[4], 4'hA, t[3:0]}; end
            2'd1: begin t = {1'b0, x} - {1'b0, y}; return {t[4], 4'h5, t[3:0]}; end
            2'd2: return 9'h128 + p;
            default: return 9'h133 + p;
        endcase
    endfunction

    always_comb alu_out  = alu_model(alu_x, alu_y, alu_s);
    always_comb alu_out3 = alu_model(alu_x3, alu_y3, alu_s3);

    arith_share_ctrl #(.SETTLE(SETTLE_A)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .x0(x0), .y0(y0), .op0(op0), .x1(x1), .y1(y1), .op1(op1),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_out(alu_out),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .dbg_state(dbg_state)
    );

    arith_share_ctrl #(.SETTLE(SETTLE_B)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req(req3),
        .x0(x03), .y0(y03), .op0(op03), .x1(x13), .y1(y13), .op1(op13),
        .alu_x(alu_x3), .alu_y(alu_y3), .alu_s(alu_s3), .alu_out(alu_out3),
        .grant(grant3), .done(done3), .result(result3), .busy(busy3),
        .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];   // {done bits, result}

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- monitor for instance A ----------------
    int         cyc = 0;
    int         grant_cyc = 0;
    int         done_cnt = 0;
    logic [1:0] prev_grant = 2'b00;
    logic [10:0] e;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
            if (done != 2'b00) begin
                chk("done_onehot_matches_grant", {14'd0, done}, {14'd0, grant});
                chk("done_latency", 16'(cyc - grant_cyc), 16'(SETTLE_A));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b result=%h expected no done", done, result);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", {5'd0, done, result}, {5'd0, e});
                end
                done_cnt++;
            end
        end
        prev_grant = grant;
    end

    // ---------------- driver tasks ----------------
    // One transaction on requester r; operands are scrambled right after the
    // grant to show the latched copy is used.
    task automatic txn(input int r, input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] op, input logic [8:0] exp_res);
        int n;
        if (r == 0) begin x0 = x; y0 = y; op0 = op; end
        else        begin x1 = x; y1 = y; op1 = op; end
        exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, exp_res});
        req[r] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!grant[r] && n < 50);
        if (!grant[r]) timeout("grant_wait");
        if (r == 0) begin x0 = ~x; y0 = ~y; op0 = ~op; end
        else        begin x1 = ~x; y1 = ~y; op1 = ~op; end
        n = 0;
        while (!done[r] && n < 50) begin @(negedge clk); n++; end
        if (!done[r]) timeout("done_wait");
        req[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 100) begin @(negedge clk); n++; end
        if (done_cnt < target) timeout("done_count_wait");
    endtask

    // ---------------- stimulus ----------------
    int n;
    int lat;

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        req = 2'b00; x0 = 0; y0 = 0; op0 = 0; x1 = 0; y1 = 0; op1 = 0;
        req3 = 2'b00; x03 = 0; y03 = 0; op03 = 0; x13 = 0; y13 = 0; op13 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;
        @(negedge clk);

        // Reset state.
        chk("reset_outputs", {grant, done, alu_s, alu_x, alu_y}, 16'd0);
        chk("reset_result_busy", {6'd0, busy, result}, 16'd0);

        // Directed single transactions (expected values computed by hand).
        txn(0, 4'h7, 4'h9, 2'b00, 9'h100);   // 7+9=16: carry, sum 0
        txn(1, 4'h3, 4'h5, 2'b01, 9'h10E);   // 3-5: borrow, diff E
        txn(0, 4'h3, 4'hA, 2'b10, 9'h146);
        txn(0, 4'h3, 4'hA, 2'b11, 9'h151);
        txn(1, 4'hF, 4'hF, 2'b00, 9'h10E);   // 15+15=30
        txn(0, 4'h2, 4'h3, 2'b01, 9'h10F);   // 2-3: borrow, diff F
        txn(1, 4'h5, 4'h2, 2'b01, 9'h003);   // no borrow
        chk("idle_busy_low", {15'd0, busy}, 16'd0);
        chk("alu_inputs_held_in_idle", {10'd0, alu_s, alu_x}, {10'd0, 2'b01, 4'h5});

        // Both requesters continuously requesting from a fresh reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        x0 = 4'h1; y0 = 4'h2; op0 = 2'b00;
        x1 = 4'h4; y1 = 4'h6; op1 = 2'b10;
        exp_q.push_back({2'b01, 9'h003});
        exp_q.push_back({2'b10, 9'h140});
        exp_q.push_back({2'b01, 9'h003});
        exp_q.push_back({2'b10, 9'h140});
        n = done_cnt;
        req = 2'b11;
        wait_dones(n + 4);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        // Instance B: reset while in EXEC.
        x03 = 4'h2; y03 = 4'h2; op03 = 2'b00;
        x13 = 4'h9; y13 = 4'h9; op13 = 2'b01;
        req3 = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (grant3 == 2'b00 && n < 50);
        chk("b_grant_before_abort", {14'd0, grant3}, 16'h0001);
        @(negedge clk);
        chk("b_busy_in_exec", {15'd0, busy3}, 16'd1);
        #1 rst3_n = 1'b0;
        #1;
        chk("b_async_reset_outputs", {grant3, done3, alu_s3, alu_x3, alu_y3}, 16'd0);
        chk("b_async_reset_result_busy", {6'd0, busy3, result3}, 16'd0);
        req3 = 2'b11;
        n = 0;
        repeat (4) begin @(negedge clk); if (done3 != 2'b00) n++; end
        chk("b_no_done_in_reset", 16'(n), 16'd0);
        rst3_n = 1'b1;

        // After release the tie goes to requester 0 again.
        n = 0;
        do begin @(negedge clk); n++; end while (grant3 == 2'b00 && n < 50);
        chk("b_first_grant_after_reset", {14'd0, grant3}, 16'h0001);
        lat = 0;
        while (done3 == 2'b00 && lat < 50) begin @(negedge clk); lat++; end
        req3 = 2'b00;
        chk("b_done_latency", 16'(lat), 16'(SETTLE_B));
        chk("b_done_result", {5'd0, done3, result3}, {5'd0, 2'b01, 9'h004});
        @(negedge clk);
        chk("b_done_single_cycle", {14'd0, done3}, 16'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
